// File: rtl/lsu_req_pkg.sv
// Shared opcodes, data memory size and FSM state encoding for the load/store initiator.
package lsu_req_pkg;

  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_JALR = 6'h13;

  localparam int unsigned DMEM_SIZE = 256;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

  function automatic logic is_link_op(input logic [5:0] op);
    return (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/lsu_timeout.sv
// Saturating cycle counter for an outstanding request; expired flags the last allowed cycle.
module lsu_timeout #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned LIMIT = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != {CW{1'b1}})) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A zero TIMEOUT never expires.
  assign expired = (TIMEOUT != 0) && (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/lsu_req.sv
// Load/store initiator: issues one word request per LW/SW over req/ack and returns writeback data.
module lsu_req
  import lsu_req_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DEPTH   = DMEM_SIZE,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              valid,
  input  logic [31:0]       Ins,
  input  logic [31:0]       Result,
  input  logic [31:0]       Rdata2,
  input  logic [31:0]       nextPC,
  output logic              stall,
  output logic [31:0]       Wdata,
  output logic              Wvalid,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  logic [5:0] op;
  logic       in_range;
  logic       accept;
  logic       expired;

  state_t              state_q,     state_d;
  logic                mem_req_q,   mem_req_d;
  logic                mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [31:0]         wdata_q,     wdata_d;
  logic                wvalid_q,    wvalid_d;
  logic                err_q,       err_d;

  assign op       = Ins[31:26];
  // Range is judged on the full Result, not just the bits that reach mem_addr.
  assign in_range = Result < 32'(DEPTH);
  assign accept   = (state_q == ST_IDLE) && valid && is_mem_op(op) && in_range;

  lsu_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (CLK),
    .rst_n  (RST),
    .clr    (accept),
    .en     ((state_q == ST_REQ) && !mem_ack),
    .expired(expired)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wdata_d     = wdata_q;
    wvalid_d    = 1'b0;
    err_d       = 1'b0;
    stall       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid) begin
          if (!is_mem_op(op)) begin
            wdata_d  = is_link_op(op) ? nextPC : Result;
            wvalid_d = 1'b1;
          end else if (!in_range) begin
            err_d = 1'b1;
          end else begin
            stall       = 1'b1;
            mem_addr_d  = Result[ADDR_W-1:0];
            mem_wdata_d = Rdata2;
            mem_we_d    = (op == OP_SW);
            mem_req_d   = 1'b1;
            state_d     = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        // Stall drops on the completing cycle so the pipeline advances on that same edge.
        stall = !mem_ack && !expired;
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = ST_IDLE;
          if (!mem_we_q) begin
            wdata_d  = mem_rdata;
            wvalid_d = 1'b1;
          end
        end else if (expired) begin
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wdata_q     <= '0;
      wvalid_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wdata_q     <= wdata_d;
      wvalid_q    <= wvalid_d;
      err_q       <= err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign Wdata     = wdata_q;
  assign Wvalid    = wvalid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_lsu_req.sv
// Self-checking bench for lsu_req: directed scenarios plus random transactions against a transaction-level model.
module tb_lsu_req;
  import lsu_req_pkg::*;

  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned DEPTH   = DMEM_SIZE;
  localparam int unsigned TIMEOUT = 16;
  localparam logic [5:0]  OP_ADD  = 6'h00;

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              valid = 1'b0;
  logic [31:0]       Ins = '0, Result = '0, Rdata2 = '0, nextPC = '0;
  logic              stall, Wvalid, err, mem_req, mem_we;
  logic [31:0]       Wdata, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack = 1'b0;
  logic [31:0]       mem_rdata = '0;

  lsu_req #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .valid(valid), .Ins(Ins), .Result(Result), .Rdata2(Rdata2),
    .nextPC(nextPC), .stall(stall), .Wdata(Wdata), .Wvalid(Wvalid), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Transaction-level model state: the last value written back.
  logic [31:0] model_wdata = '0;

  // Observations gathered by the driver for one transaction.
  int o_req, o_stall, o_wvalid, o_err, o_both;
  logic              o_we, o_stable;
  logic [ADDR_W-1:0] o_addr;
  logic [31:0]       o_mwdata, o_wdata;

  // Presents one instruction, acks the d-th request cycle (d=0: never), then watches completion plus one idle cycle.
  task automatic do_txn(input logic [5:0] op, input logic [31:0] res, input logic [31:0] rd2,
                        input logic [31:0] npc, input int d, input logic [31:0] rdata);
    @(negedge CLK);
    valid = 1'b1; Ins = {op, 26'($urandom)}; Result = res; Rdata2 = rd2; nextPC = npc; mem_ack = 1'b0;
    o_req = 0; o_stall = 0; o_wvalid = 0; o_err = 0; o_both = 0; o_stable = 1'b1;
    o_we = 1'b0; o_addr = '0; o_mwdata = '0;
    #1; if (stall) o_stall++;
    @(negedge CLK);
    valid = 1'b0; Ins = $urandom; Result = $urandom; Rdata2 = $urandom; nextPC = $urandom;
    if (mem_req) begin o_we = mem_we; o_addr = mem_addr; o_mwdata = mem_wdata; end
    while (mem_req) begin
      o_req++;
      if (mem_we !== o_we || mem_addr !== o_addr || mem_wdata !== o_mwdata) o_stable = 1'b0;
      o_wvalid += int'(Wvalid); o_err += int'(err);
      if (o_req == d) begin mem_ack = 1'b1; mem_rdata = rdata; end
      else begin mem_ack = 1'b0; mem_rdata = $urandom; end
      #1; if (stall) o_stall++;
      @(negedge CLK);
      mem_ack = 1'b0;
      if (o_req > 40) begin
        errors++;
        $display("FAIL req_bound mem_req still high after %0d cycles, required drop within %0d", o_req, TIMEOUT);
        break;
      end
    end
    for (int k = 0; k < 2; k++) begin
      o_wvalid += int'(Wvalid); o_err += int'(err); o_both += int'(Wvalid && err);
      if (k == 0) o_wdata = Wdata;
      #1; if (stall) o_stall++;
      @(negedge CLK);
    end
  endtask

  // Expected outcome of one transaction, computed from the architectural rules.
  task automatic model_txn(input logic [5:0] op, input logic [31:0] res, input logic [31:0] npc,
                           input logic [31:0] rdata, input int d,
                           output int e_req, output int e_stall, output int e_wvalid, output int e_err);
    e_req = 0; e_stall = 0; e_wvalid = 0; e_err = 0;
    if (!(op == OP_LW || op == OP_SW)) begin
      e_wvalid = 1;
      model_wdata = (op == OP_JAL || op == OP_JALR) ? npc : res;
    end else if (res >= DEPTH) begin
      e_err = 1;
    end else if (d >= 1 && d <= int'(TIMEOUT)) begin
      e_req = d; e_stall = d;
      if (op == OP_LW) begin e_wvalid = 1; model_wdata = rdata; end
    end else begin
      e_req = TIMEOUT; e_stall = TIMEOUT; e_err = 1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    checks++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin errors++; $display("FAIL reset_mem got req=%b we=%b addr=%h wd=%h exp all 0", mem_req, mem_we, mem_addr, mem_wdata); end
    checks++; if ({Wdata, Wvalid, err, stall} !== '0) begin errors++; $display("FAIL reset_wb got wdata=%h wvalid=%b err=%b stall=%b exp all 0", Wdata, Wvalid, err, stall); end
    RST = 1'b1;
    model_wdata = '0;
  endtask

  task automatic test_alu();
    do_txn(OP_ADD, 32'h12, 32'h0, 32'h0, 0, 32'h0);
    $display("txn ADD res=12 wvalid=%0d wdata=%h stall=%0d", o_wvalid, o_wdata, o_stall);
    checks++; if (o_wdata !== 32'h12) begin errors++; $display("FAIL add_wdata got=%h exp=%h", o_wdata, 32'h12); end
    checks++; if (o_wvalid !== 1 || o_err !== 0) begin errors++; $display("FAIL add_pulses got wvalid=%0d err=%0d exp 1/0", o_wvalid, o_err); end
    checks++; if (o_stall !== 0 || o_req !== 0) begin errors++; $display("FAIL add_stall got stall=%0d req=%0d exp 0/0", o_stall, o_req); end
    do_txn(OP_JAL, 32'h99, 32'h0, 32'h40, 0, 32'h0);
    $display("txn JAL res=99 npc=40 wvalid=%0d wdata=%h", o_wvalid, o_wdata);
    checks++; if (o_wdata !== 32'h40) begin errors++; $display("FAIL jal_wdata got=%h exp=%h", o_wdata, 32'h40); end
    model_wdata = 32'h40;
  endtask

  task automatic test_store();
    do_txn(OP_SW, 32'd5, 32'hCAFE, 32'h0, 3, 32'h0);
    $display("txn SW res=5 data=CAFE req=%0d we=%b addr=%h wd=%h stall=%0d", o_req, o_we, o_addr, o_mwdata, o_stall);
    checks++; if (o_req !== 3) begin errors++; $display("FAIL sw_req_cycles got=%0d exp=3", o_req); end
    checks++; if (o_we !== 1'b1 || o_addr !== 10'd5 || o_mwdata !== 32'hCAFE) begin errors++; $display("FAIL sw_fields got we=%b addr=%h wd=%h exp 1/005/0000cafe", o_we, o_addr, o_mwdata); end
    checks++; if (o_stable !== 1'b1) begin errors++; $display("FAIL sw_stable got=%b exp=1", o_stable); end
    checks++; if (o_stall !== 3) begin errors++; $display("FAIL sw_stall got=%0d exp=3", o_stall); end
    checks++; if (o_wvalid !== 0 || o_err !== 0 || o_wdata !== model_wdata) begin errors++; $display("FAIL sw_wb got wvalid=%0d err=%0d wdata=%h exp 0/0/%h", o_wvalid, o_err, o_wdata, model_wdata); end
  endtask

  task automatic test_back_to_back();
    @(negedge CLK);
    valid = 1'b1; Ins = {OP_LW, 26'h0}; Result = 32'd5; mem_ack = 1'b0;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_t0_stall got=%b exp=1", stall); end
    @(negedge CLK);
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'd5) begin errors++; $display("FAIL b2b_t1_req got req=%b we=%b addr=%h exp 1/0/005", mem_req, mem_we, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'hCAFE;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_t1_stall got=%b exp=0", stall); end
    @(negedge CLK);
    mem_ack = 1'b0; mem_rdata = $urandom; Ins = {OP_ADD, 26'h0}; Result = 32'h77;
    checks++; if (Wvalid !== 1'b1 || Wdata !== 32'hCAFE || mem_req !== 1'b0) begin errors++; $display("FAIL b2b_t2_load got wvalid=%b wdata=%h req=%b exp 1/0000cafe/0", Wvalid, Wdata, mem_req); end
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_t2_stall got=%b exp=0", stall); end
    @(negedge CLK);
    valid = 1'b0;
    checks++; if (Wvalid !== 1'b1 || Wdata !== 32'h77 || err !== 1'b0) begin errors++; $display("FAIL b2b_t3_add got wvalid=%b wdata=%h err=%b exp 1/00000077/0", Wvalid, Wdata, err); end
    $display("txn LW+ADD back-to-back wdata=%h", Wdata);
    model_wdata = 32'h77;
  endtask

  task automatic test_range();
    do_txn(OP_LW, DEPTH, 32'h0, 32'h0, 1, 32'h1234);
    $display("txn LW res=DEPTH req=%0d err=%0d wvalid=%0d", o_req, o_err, o_wvalid);
    checks++; if (o_req !== 0 || o_err !== 1 || o_wvalid !== 0) begin errors++; $display("FAIL lw_range got req=%0d err=%0d wvalid=%0d exp 0/1/0", o_req, o_err, o_wvalid); end
    checks++; if (o_stall !== 0 || o_wdata !== model_wdata) begin errors++; $display("FAIL lw_range_wb got stall=%0d wdata=%h exp 0/%h", o_stall, o_wdata, model_wdata); end
    do_txn(OP_SW, 32'd1024 + 32'd5, 32'hBEEF, 32'h0, 1, 32'h0);
    checks++; if (o_req !== 0 || o_err !== 1) begin errors++; $display("FAIL sw_range_wide got req=%0d err=%0d exp 0/1", o_req, o_err); end
    @(negedge CLK);
    mem_ack = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      checks++; if (Wvalid !== 1'b0 || err !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL idle_ack got wvalid=%b err=%b req=%b exp 0/0/0", Wvalid, err, mem_req); end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_timeout();
    do_txn(OP_LW, 32'd9, 32'h0, 32'h0, 0, 32'h0);
    $display("txn LW no-ack req=%0d err=%0d stall=%0d", o_req, o_err, o_stall);
    checks++; if (o_req !== int'(TIMEOUT)) begin errors++; $display("FAIL to_req_cycles got=%0d exp=%0d", o_req, TIMEOUT); end
    checks++; if (o_err !== 1 || o_wvalid !== 0) begin errors++; $display("FAIL to_err got err=%0d wvalid=%0d exp 1/0", o_err, o_wvalid); end
    checks++; if (o_stall !== int'(TIMEOUT)) begin errors++; $display("FAIL to_stall got=%0d exp=%0d", o_stall, TIMEOUT); end
    do_txn(OP_LW, 32'd9, 32'h0, 32'h0, TIMEOUT, 32'h5A5A_0001);
    $display("txn LW ack@limit req=%0d err=%0d wvalid=%0d wdata=%h", o_req, o_err, o_wvalid, o_wdata);
    checks++; if (o_err !== 0 || o_wvalid !== 1 || o_wdata !== 32'h5A5A_0001) begin errors++; $display("FAIL to_ack_wins got err=%0d wvalid=%0d wdata=%h exp 0/1/5a5a0001", o_err, o_wvalid, o_wdata); end
    model_wdata = 32'h5A5A_0001;
  endtask

  task automatic test_reset_mid_req();
    @(negedge CLK);
    valid = 1'b1; Ins = {OP_SW, 26'h0}; Result = 32'd7; Rdata2 = 32'hD00D; mem_ack = 1'b0;
    @(negedge CLK);
    valid = 1'b0;
    @(negedge CLK);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_pre_req got=%b exp=1", mem_req); end
    #2 RST = 1'b0;
    #1;
    checks++; if ({mem_req, mem_we, mem_addr, mem_wdata, Wdata, Wvalid, err, stall} !== '0) begin errors++; $display("FAIL rst_mid_req got req=%b we=%b addr=%h wd=%h wdata=%h wvalid=%b err=%b stall=%b exp all 0", mem_req, mem_we, mem_addr, mem_wdata, Wdata, Wvalid, err, stall); end
    @(negedge CLK);
    RST = 1'b1;
    model_wdata = '0;
    do_txn(OP_ADD, 32'h3C, 32'h0, 32'h0, 0, 32'h0);
    checks++; if (o_wdata !== 32'h3C || o_wvalid !== 1) begin errors++; $display("FAIL rst_recover got wdata=%h wvalid=%0d exp 0000003c/1", o_wdata, o_wvalid); end
    model_wdata = 32'h3C;
  endtask

  task automatic test_random();
    logic [5:0]  op;
    logic [31:0] res, rd2, npc, rdata;
    int d, r, e_req, e_stall, e_wvalid, e_err;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: op = OP_LW;
        1: op = OP_SW;
        2: op = OP_JAL;
        3: op = OP_JALR;
        4: op = OP_ADD;
        default: begin
          op = 6'($urandom);
          if (op == OP_LW || op == OP_SW) op = OP_ADD;
        end
      endcase
      r = $urandom_range(0, 9);
      if (r == 0)      res = $urandom;
      else if (r == 1) res = DEPTH + $urandom_range(0, 3);
      else if (r == 2) res = DEPTH - 1;
      else             res = $urandom_range(0, DEPTH - 1);
      rd2 = $urandom; npc = $urandom; rdata = $urandom;
      d = $urandom_range(0, TIMEOUT + 2);
      do_txn(op, res, rd2, npc, d, rdata);
      model_txn(op, res, npc, rdata, d, e_req, e_stall, e_wvalid, e_err);
      $display("txn %0d op=%h res=%h d=%0d req=%0d stall=%0d wvalid=%0d err=%0d wdata=%h", i, op, res, d, o_req, o_stall, o_wvalid, o_err, o_wdata);
      checks++; if (o_req !== e_req || o_stall !== e_stall) begin errors++; $display("FAIL rnd%0d_req got req=%0d stall=%0d exp %0d/%0d", i, o_req, o_stall, e_req, e_stall); end
      checks++; if (o_wvalid !== e_wvalid || o_err !== e_err || o_both !== 0) begin errors++; $display("FAIL rnd%0d_pulse got wvalid=%0d err=%0d both=%0d exp %0d/%0d/0", i, o_wvalid, o_err, o_both, e_wvalid, e_err); end
      checks++; if (o_wdata !== model_wdata) begin errors++; $display("FAIL rnd%0d_wdata got=%h exp=%h", i, o_wdata, model_wdata); end
      if (e_req != 0) begin
        checks++; if (o_we !== (op == OP_SW) || o_addr !== res[ADDR_W-1:0] || (op == OP_SW && o_mwdata !== rd2) || o_stable !== 1'b1) begin errors++; $display("FAIL rnd%0d_req_fields got we=%b addr=%h wd=%h stable=%b exp we=%b addr=%h wd=%h", i, o_we, o_addr, o_mwdata, o_stable, (op == OP_SW), res[ADDR_W-1:0], rd2); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store();
    test_back_to_back();
    test_range();
    test_timeout();
    test_reset_mid_req();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/lsu_req.md
Name: lsu_req

Overview:
- Load/store initiator between the execute stage and the data memory.
- Takes the decoded instruction, ALU Result and Rdata2, and issues a word request over a req/ack handshake to a variable-latency data memory.
- Returns writeback data and stalls the pipeline while a request is outstanding.
- Keeps the existing writeback selection: LW gives memory data, JAL/JALR give nextPC, every other op gives Result.

Parameters:
- ADDR_W, 10, width of mem_addr (word index).
- DEPTH, DMEM_SIZE, number of valid words; any word index >= DEPTH is a range error.
- TIMEOUT, 16, maximum cycles spent in REQ without mem_ack; 0 disables the timeout.

Ports:
- CLK  in  1  clock; all state changes on its rising edge.
- RST  in  1  asynchronous, active-low reset.
- valid  in  1  Ins/Result/Rdata2/nextPC are valid this cycle.
- Ins  in  32  instruction; op = Ins[31:26].
- Result  in  32  ALU result; used directly as the word index.
- Rdata2  in  32  store data.
- nextPC  in  32  return address for JAL/JALR.
- stall  out  1  pipeline must hold its inputs this cycle.
- Wdata  out  32  writeback data, registered.
- Wvalid  out  1  Wdata is new this cycle (1-cycle pulse).
- err  out  1  1-cycle pulse on a range error or timeout.
- mem_req  out  1  request to memory, registered.
- mem_we  out  1  1 = write (SW), 0 = read (LW).
- mem_addr  out  ADDR_W  word index = latched Result[ADDR_W-1:0].
- mem_wdata  out  32  latched Rdata2.
- mem_ack  in  1  memory has accepted or completed the request this cycle.
- mem_rdata  in  32  read data, valid when mem_ack=1 and mem_we=0.

Behaviour:
- Reset (RST=0, async): state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, Wdata=0, Wvalid=0, err=0; timeout counter=0.
- States: IDLE and REQ.
- IDLE, valid=1, op not LW/SW:
  - next edge: Wdata <= (op==JAL||op==JALR) ? nextPC : Result; Wvalid=1.
  - stall=0; latency 1 cycle.
- IDLE, valid=1, op is LW/SW, Result >= DEPTH:
  - no request; err=1 next cycle; stall=0.
  - LW: Wdata unchanged, Wvalid=0. SW: memory untouched.
- IDLE, valid=1, op is LW/SW, in range:
  - stall=1 (combinational).
  - next edge: latch mem_addr, mem_wdata, mem_we=(op==SW); mem_req=1; counter=0; go to REQ.
- REQ:
  - mem_req held 1; mem_addr, mem_we, mem_wdata stable; stall = !mem_ack.
  - Inputs are ignored; the pipeline holds them.
- REQ, mem_ack=1:
  - next edge: mem_req=0; go to IDLE.
  - LW: Wdata=mem_rdata, Wvalid=1. SW: Wvalid=0.
  - Stall drops in the ack cycle, so the pipeline advances on that same edge.
  - Minimum LW latency is 2 cycles (accept at T0, ack at T1, Wvalid at T2).
- REQ, no ack:
  - counter += 1.
  - When TIMEOUT!=0 and counter==TIMEOUT-1 and mem_ack=0: stall=0; next edge mem_req=0, err=1, Wvalid=0, go to IDLE.
  - Ack and timeout in the same cycle: ack wins, no err.
- mem_ack while in IDLE: ignored.
- valid=0 in IDLE: no action; Wvalid=0, err=0.
- Reset asserted in REQ: request dropped immediately; the memory side must tolerate mem_req falling without an ack.
- Wvalid and err are never both 1 in the same cycle.
- Counter width is $clog2(TIMEOUT+1) and it saturates; it never wraps.

Decomposition:
- common_param.vh (shared): opcodes LW, SW, JAL, JALR; DMEM_SIZE; state encodings ST_IDLE, ST_REQ.
- One natural sub-module, lsu_timeout: counter with clear/enable inputs and an expired output, parameterised by TIMEOUT.

Test Plan:
- Reset, then ADD with Result=32'h12: Wdata=32'h12 and Wvalid=1 one cycle later; stall never 1.
- JAL with nextPC=32'h40, Result=32'h99: Wdata=32'h40.
- SW with Result=5, Rdata2=32'hCAFE, ack after 3 REQ cycles: mem_req=1 with mem_we=1, addr=5, wdata=32'hCAFE for 3 cycles; stall=1 until the ack cycle; Wvalid stays 0.
- LW with Result=5, ack on the first REQ cycle, mem_rdata=32'hCAFE: Wdata=32'hCAFE and Wvalid=1 at T2; a following ADD is accepted at T2 with no bubble.
- LW with Result=DEPTH: no mem_req; err pulses once; stall=0.
- LW with no ack and TIMEOUT=16: mem_req high 16 cycles, then err=1 and return to IDLE. Repeat with ack on the 16th cycle: no err and Wvalid=1. Separately, drop RST mid-REQ: all outputs 0 at once.
